// File: rtl/wb_regfile.sv
// wb_regfile: write-back commit into GPR file, HI/LO and LLbit with same-cycle bypassed reads
module wb_regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] waddr_i,
  input  logic          wena_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          hilo_ena_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic          LL_ena_i,
  input  logic          LL_data_i,
  input  logic          ll_clear,
  input  logic [AW-1:0] raddr1,
  input  logic          rena1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  input  logic          rena2,
  output logic [DW-1:0] rdata2,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          llbit_o
);
  logic [DW-1:0] gpr [2**AW];
  logic [DW-1:0] hi, lo;
  logic          ll;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) gpr[i] <= '0;
      hi <= '0;
      lo <= '0;
      ll <= 1'b0;
    end else begin
      if (wena_i && waddr_i != '0) gpr[waddr_i] <= wdata_i;
      if (hilo_ena_i) begin
        hi <= hi_i;
        lo <= lo_i;
      end
      ll <= ll_clear ? 1'b0 : LL_ena_i ? LL_data_i : ll;
    end
  end
  always_comb begin
    rdata1  = (rst || !rena1 || raddr1 == '0) ? '0 : (wena_i && waddr_i == raddr1) ? wdata_i : gpr[raddr1];
    rdata2  = (rst || !rena2 || raddr2 == '0) ? '0 : (wena_i && waddr_i == raddr2) ? wdata_i : gpr[raddr2];
    hi_o    = rst ? '0 : hilo_ena_i ? hi_i : hi;
    lo_o    = rst ? '0 : hilo_ena_i ? lo_i : lo;
    llbit_o = rst ? 1'b0 : ll_clear ? 1'b0 : LL_ena_i ? LL_data_i : ll;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and random checks of wb_regfile against a behavioural model
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  waddr_i, raddr1, raddr2;
  logic        wena_i, hilo_ena_i, LL_ena_i, LL_data_i, ll_clear, rena1, rena2;
  logic [31:0] wdata_i, hi_i, lo_i, rdata1, rdata2, hi_o, lo_o;
  logic        llbit_o;
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  logic        m_ll;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  wb_regfile dut (
    .clk(clk), .rst(rst), .waddr_i(waddr_i), .wena_i(wena_i), .wdata_i(wdata_i),
    .hilo_ena_i(hilo_ena_i), .hi_i(hi_i), .lo_i(lo_i), .LL_ena_i(LL_ena_i),
    .LL_data_i(LL_data_i), .ll_clear(ll_clear), .raddr1(raddr1), .rena1(rena1),
    .rdata1(rdata1), .raddr2(raddr2), .rena2(rena2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .llbit_o(llbit_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'd0;
    if (wena_i && waddr_i == a) return wdata_i;
    return m_gpr[a];
  endfunction
  task automatic idle();
    rst = 1'b0; wena_i = 1'b0; hilo_ena_i = 1'b0; LL_ena_i = 1'b0; ll_clear = 1'b0;
    waddr_i = '0; wdata_i = '0; hi_i = '0; lo_i = '0; LL_data_i = 1'b0;
  endtask
  task automatic cyc();
    #1;
    chk("rdata1", rdata1, exp_rd(rena1, raddr1));
    chk("rdata2", rdata2, exp_rd(rena2, raddr2));
    chk("hi_o", hi_o, rst ? 32'd0 : hilo_ena_i ? hi_i : m_hi);
    chk("lo_o", lo_o, rst ? 32'd0 : hilo_ena_i ? lo_i : m_lo);
    chk("llbit_o", {31'd0, llbit_o}, {31'd0, (rst || ll_clear) ? 1'b0 : LL_ena_i ? LL_data_i : m_ll});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_hi = '0; m_lo = '0; m_ll = 1'b0;
    end else begin
      if (wena_i && waddr_i != 5'd0) m_gpr[waddr_i] = wdata_i;
      if (hilo_ena_i) begin m_hi = hi_i; m_lo = lo_i; end
      if (ll_clear) m_ll = 1'b0;
      else if (LL_ena_i) m_ll = LL_data_i;
    end
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = 'x;
    m_hi = 'x; m_lo = 'x; m_ll = 1'bx;
    idle();
    rena1 = 1'b1; rena2 = 1'b1; raddr1 = 5'd5; raddr2 = 5'd31;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("reset_rd1", rdata1, 32'd0);
    chk("reset_rd2", rdata2, 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_ll", {31'd0, llbit_o}, 32'd0);
    cyc();
    wena_i = 1'b1; waddr_i = 5'd8; wdata_i = 32'hDEADBEEF;
    cyc();
    wena_i = 1'b0; raddr1 = 5'd8;
    #1 chk("read8", rdata1, 32'hDEADBEEF);
    cyc();
    rena1 = 1'b0;
    #1 chk("read8_disabled", rdata1, 32'd0);
    cyc();
    rena1 = 1'b1; wena_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'h1234; raddr1 = 5'd0;
    #1 chk("r0_same", rdata1, 32'd0);
    cyc();
    wena_i = 1'b0;
    #1 chk("r0_later", rdata1, 32'd0);
    cyc();
    wena_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'hA5A5A5A5; raddr1 = 5'd3; raddr2 = 5'd3;
    #1 chk("bypass1", rdata1, 32'hA5A5A5A5);
    chk("bypass2", rdata2, 32'hA5A5A5A5);
    cyc();
    wena_i = 1'b0; hilo_ena_i = 1'b1; hi_i = 32'h1; lo_i = 32'hFFFFFFFE;
    #1 chk("hi_byp", hi_o, 32'h1);
    chk("lo_byp", lo_o, 32'hFFFFFFFE);
    cyc();
    hilo_ena_i = 1'b0; hi_i = 32'h55; lo_i = 32'h66;
    #1 chk("hi_hold", hi_o, 32'h1);
    chk("lo_hold", lo_o, 32'hFFFFFFFE);
    cyc();
    LL_ena_i = 1'b1; LL_data_i = 1'b1;
    #1 chk("ll_set", {31'd0, llbit_o}, 32'd1);
    cyc();
    LL_ena_i = 1'b0;
    #1 chk("ll_stored", {31'd0, llbit_o}, 32'd1);
    cyc();
    ll_clear = 1'b1; LL_ena_i = 1'b1; LL_data_i = 1'b1;
    #1 chk("ll_clear_prio", {31'd0, llbit_o}, 32'd0);
    cyc();
    ll_clear = 1'b0; LL_ena_i = 1'b0;
    #1 chk("ll_cleared", {31'd0, llbit_o}, 32'd0);
    cyc();
    rst = 1'b1; wena_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'd7; hilo_ena_i = 1'b1;
    cyc();
    idle();
    raddr1 = 5'd9; raddr2 = 5'd8;
    #1 chk("mid_rst_gpr9", rdata1, 32'd0);
    chk("mid_rst_gpr8", rdata2, 32'd0);
    chk("mid_rst_hi", hi_o, 32'd0);
    chk("mid_rst_lo", lo_o, 32'd0);
    cyc();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      wena_i = $urandom_range(0, 1) == 1;
      waddr_i = 5'($urandom);
      wdata_i = $urandom;
      hilo_ena_i = $urandom_range(0, 3) == 0;
      hi_i = $urandom; lo_i = $urandom;
      LL_ena_i = $urandom_range(0, 3) == 0;
      LL_data_i = 1'($urandom);
      ll_clear = $urandom_range(0, 7) == 0;
      rena1 = $urandom_range(0, 7) != 0;
      rena2 = $urandom_range(0, 7) != 0;
      raddr1 = $urandom_range(0, 3) == 0 ? waddr_i : 5'($urandom);
      raddr2 = $urandom_range(0, 3) == 0 ? waddr_i : 5'($urandom);
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
